ql_bank_cfg_loader: RTL and testbench
=====================================

# ql_bank_cfg_loader

On-chip configuration programmer for the QL memory-bank fabric. It accepts the bitstream as a valid/ready word stream and assembles each row into the bit-line bus. It then strobes exactly one word line per row until every row is written, and releases the fabric's global reset once programming completes. It sits between the bitstream source (SPI/JTAG front end or bench driver) and the `fpga_top` ports `bl_config_region_0`, `wl_config_region_0` and `global_resetn`.

## Interface
- `BL_WIDTH`, 514: bit lines per row (width of `bl_config_region_0`).
- `WL_WIDTH`, 407: word lines, which is the number of rows.
- `DATA_W`, 32: stream word width.
- `WL_PULSE`, 4: cycles each word line is held high; legal range 1..255.
- `clk`  in  1  single clock; every flop is on its rising edge.
- `global_resetn`  in  1  asynchronous, active-low reset.
- `cfg_start`  in  1  one-cycle start request; acted on only in IDLE.
- `cfg_data`  in  DATA_W  bitstream word.
- `cfg_valid`  in  1  `cfg_data` is valid.
- `cfg_ready`  out  1  loader accepts the word; a transfer occurs when valid && ready.
- `bl`  out  [0:BL_WIDTH-1]  registered bit-line data, driven to `bl_config_region_0`.
- `wl`  out  [0:WL_WIDTH-1]  registered word-line strobes, one-hot or zero, driven to `wl_config_region_0`.
- `fabric_resetn`  out  1  drives fabric `global_resetn`; goes high only after a successful load.
- `cfg_busy`  out  1  high in every state except IDLE and DONE.
- `cfg_done`  out  1  sticky; high in DONE.
- `cfg_err`  out  1  sticky error flag, cleared by the next accepted `cfg_start`.

## Operation
- `WPR` = ceil(BL_WIDTH/DATA_W) words per row.
- Row bit k maps to `bl[k]` and comes from word k/DATA_W, bit k%DATA_W.
- Unused high bits of the last word in a row are ignored.
- Rows are written in order from `wl[0]` to `wl[WL_WIDTH-1]`.
- State machine:
  - IDLE: `cfg_ready`=0. `cfg_start` clears `cfg_err`, zeroes the row and word counters and `bl`, and moves to LOAD.
  - LOAD: `cfg_ready`=1. Each transfer writes its slice into `bl` and increments the word counter. The transfer of word WPR-1 moves to SETUP.
  - SETUP: 1 cycle with `bl` stable, then go to PULSE.
  - PULSE: `wl[row]`=1 for WL_PULSE cycles, then go to HOLD.
  - HOLD: 1 cycle with `wl` all zero and `bl` unchanged.
    - If row < WL_WIDTH-1: increment row, clear the word counter, return to LOAD.
    - Otherwise go to CRC if `QL_CFG_CRC_EN` is defined, else go to DONE.
  - DONE: `cfg_done`=1. `fabric_resetn`=1 unless `cfg_err`=1. `bl` and `wl` are zero. `cfg_start` restarts the sequence and drops `fabric_resetn` and `cfg_done` in the same cycle.
- `cfg_start` while busy is ignored and sets `cfg_err`. The load in progress continues unaffected.
- A stalled stream (valid low in LOAD) holds state indefinitely. There is no timeout.
- `cfg_valid` outside LOAD or CRC is ignored; no transfer occurs.

## Timing
- Reset values: `bl`=0, `wl`=0, `cfg_ready`=0, `fabric_resetn`=0, `cfg_busy`=0, `cfg_done`=0, `cfg_err`=0, state=IDLE, all counters 0.
- Asserting reset mid-load aborts immediately. All outputs return to reset values asynchronously, so no partial `wl` pulse survives.
- `cfg_ready` is a registered state decode with no combinational path from `cfg_valid`.
- The first `cfg_ready` appears the cycle after `cfg_start` is sampled.
- Per-row cycles = (WPR transfer cycles) + 1 + WL_PULSE + 1.
- `bl` changes only in LOAD, so it is stable from SETUP through HOLD.
- `fabric_resetn` rises in the cycle DONE is entered.

## Configuration
- `QL_CFG_CRC_EN` defined:
  - A CRC-16/CCITT (poly 0x1021, init 0xFFFF, MSB-first over all DATA_W bits) runs over every accepted row word.
  - After the last row the loader enters CRC with `cfg_ready`=1 and accepts one trailer word.
  - `cfg_data[15:0]` must equal the CRC. On mismatch, set `cfg_err`; DONE is still entered but `fabric_resetn` stays 0.
- `QL_CFG_CRC_EN` undefined: there is no CRC logic and no CRC state, and HOLD of the last row goes straight to DONE.

## Test plan
- Test parameters: BL_WIDTH=40, WL_WIDTH=3, WL_PULSE=2, so WPR=2.
- Nominal load: start, then 6 words with valid always high.
  - After row0 words 0xA5A5A5A5 and 0x000000C3: `bl[0:31]` holds word 0, `bl[32:39]`=0xC3, and `wl`=100 for exactly 2 cycles.
  - `cfg_done` and `fabric_resetn` reach 1 after 3 rows.
- Backpressure: hold `cfg_valid` low 5 cycles between words.
  - `wl` stays 0 during the stall.
  - Total time grows by exactly 5 cycles per stall.
  - Final `bl`/`wl` pulse sequence is identical to the nominal load.
- Reset mid-PULSE: drop `global_resetn` while `wl`=010.
  - `wl`, `bl` and `fabric_resetn` go to 0 immediately.
  - After release the state is IDLE and `cfg_ready`=0.
- Busy start: pulse `cfg_start` during row 1 LOAD.
  - `cfg_err`=1 and the load completes normally.
  - `fabric_resetn` stays 0 in DONE (error blocks release).
  - The next `cfg_start` clears `cfg_err`.
- CRC (`QL_CFG_CRC_EN` defined):
  - Correct trailer: `cfg_done`=1, `fabric_resetn`=1.
  - Trailer with bit 0 flipped: `cfg_err`=1, `fabric_resetn`=0.
- Restart from DONE: second `cfg_start` drops `fabric_resetn` and `cfg_done` in the start cycle; a full reload then completes.

Source files
------------

// File: rtl/ql_bank_cfg_loader_if.sv
// Bitstream word stream (valid/ready) between the configuration source and ql_bank_cfg_loader.
interface ql_bank_cfg_loader_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;

   modport master (output cfg_data, output cfg_valid, input cfg_ready);
   modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ql_bank_cfg_loader.sv
// QL memory-bank configuration programmer: assembles bitstream rows onto bl and strobes one wl per row.
// Optional trailer CRC-16/CCITT check is compiled in with `define QL_CFG_CRC_EN.
module ql_bank_cfg_loader #(
   parameter int BL_WIDTH = 514,
   parameter int WL_WIDTH = 407,
   parameter int DATA_W   = 32,
   parameter int WL_PULSE = 4
) (
   input  logic                 clk,
   input  logic                 global_resetn,
   input  logic                 cfg_start,
   ql_bank_cfg_loader_if.slave  cfg,
   output logic [0:BL_WIDTH-1]  bl,
   output logic [0:WL_WIDTH-1]  wl,
   output logic                 fabric_resetn,
   output logic                 cfg_busy,
   output logic                 cfg_done,
   output logic                 cfg_err
);

   localparam int WPR = (BL_WIDTH + DATA_W - 1) / DATA_W;
   localparam int WCW = (WPR > 1) ? $clog2(WPR) : 1;
   localparam int RCW = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
   localparam logic [WCW-1:0] LAST_WORD  = WCW'(WPR - 1);
   localparam logic [RCW-1:0] LAST_ROW   = RCW'(WL_WIDTH - 1);
   localparam logic [7:0]     LAST_PULSE = 8'(WL_PULSE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETUP,
      S_PULSE,
      S_HOLD,
`ifdef QL_CFG_CRC_EN
      S_CRC,
`endif
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [WCW-1:0]     word_q, word_d;
   logic [RCW-1:0]     row_q, row_d;
   logic [7:0]         pulse_q, pulse_d;
   logic [0:BL_WIDTH-1] bl_d;
   logic [0:WL_WIDTH-1] wl_d;
   logic               err_q, err_d;
   logic               ready_q, ready_d;
   logic               fab_q, fab_d;
   logic               xfer;

`ifdef QL_CFG_CRC_EN
   logic [15:0]        crc_q, crc_d;

   // CRC-16/CCITT, polynomial 0x1021, consuming the word MSB first
   function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                              input logic [DATA_W-1:0] data);
      logic [15:0] c;
      c = crc_in;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else                 c = {c[14:0], 1'b0};
      end
      return c;
   endfunction
`endif

   assign cfg.cfg_ready  = ready_q;
   assign xfer           = cfg.cfg_valid && ready_q;
   assign cfg_busy       = (state_q != S_IDLE) && (state_q != S_DONE);
   assign cfg_done       = (state_q == S_DONE);
   assign cfg_err        = err_q;
   assign fabric_resetn  = fab_q;

   // Next-state logic; ready, wl and fabric reset are registered decodes of the next state
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      row_d   = row_q;
      pulse_d = pulse_q;
      bl_d    = bl;
      err_d   = err_q;
`ifdef QL_CFG_CRC_EN
      crc_d   = crc_q;
`endif

      if (cfg_start) begin
         if ((state_q == S_IDLE) || (state_q == S_DONE)) begin
            state_d = S_LOAD;
            word_d  = '0;
            row_d   = '0;
            bl_d    = '0;
            err_d   = 1'b0;
`ifdef QL_CFG_CRC_EN
            crc_d   = 16'hFFFF;
`endif
         end else begin
            err_d = 1'b1;
         end
      end

      case (state_q)
         S_LOAD: begin
            if (xfer) begin
               for (int k = 0; k < BL_WIDTH; k++) begin
                  if ((k / DATA_W) == int'(word_q)) bl_d[k] = cfg.cfg_data[k % DATA_W];
               end
`ifdef QL_CFG_CRC_EN
               crc_d = crc16_word(crc_q, cfg.cfg_data);
`endif
               if (word_q == LAST_WORD) state_d = S_SETUP;
               else                     word_d  = word_q + WCW'(1);
            end
         end
         S_SETUP: begin
            state_d = S_PULSE;
            pulse_d = '0;
         end
         S_PULSE: begin
            if (pulse_q == LAST_PULSE) state_d = S_HOLD;
            else                       pulse_d = pulse_q + 8'd1;
         end
         S_HOLD: begin
            if (row_q != LAST_ROW) begin
               row_d   = row_q + RCW'(1);
               word_d  = '0;
               state_d = S_LOAD;
            end else begin
`ifdef QL_CFG_CRC_EN
               state_d = S_CRC;
`else
               state_d = S_DONE;
               bl_d    = '0;
`endif
            end
         end
`ifdef QL_CFG_CRC_EN
         S_CRC: begin
            if (xfer) begin
               if (cfg.cfg_data[15:0] != crc_q) err_d = 1'b1;
               state_d = S_DONE;
               bl_d    = '0;
            end
         end
`endif
         default: ;
      endcase

`ifdef QL_CFG_CRC_EN
      ready_d = (state_d == S_LOAD) || (state_d == S_CRC);
`else
      ready_d = (state_d == S_LOAD);
`endif
      fab_d = (state_d == S_DONE) && !err_d;
      for (int r = 0; r < WL_WIDTH; r++) begin
         wl_d[r] = (state_d == S_PULSE) && (row_q == RCW'(r));
      end
   end

   // Async reset clears every output at once so no partial word-line pulse survives
   always_ff @(posedge clk or negedge global_resetn) begin
      if (!global_resetn) begin
         state_q <= S_IDLE;
         word_q  <= '0;
         row_q   <= '0;
         pulse_q <= '0;
         bl      <= '0;
         wl      <= '0;
         err_q   <= 1'b0;
         ready_q <= 1'b0;
         fab_q   <= 1'b0;
`ifdef QL_CFG_CRC_EN
         crc_q   <= 16'hFFFF;
`endif
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         row_q   <= row_d;
         pulse_q <= pulse_d;
         bl      <= bl_d;
         wl      <= wl_d;
         err_q   <= err_d;
         ready_q <= ready_d;
         fab_q   <= fab_d;
`ifdef QL_CFG_CRC_EN
         crc_q   <= crc_d;
`endif
      end
   end

endmodule

// File: tb/tb_ql_bank_cfg_loader.sv
// Directed, table-driven bench for ql_bank_cfg_loader with BL_WIDTH=40, WL_WIDTH=3, WL_PULSE=2 (two words per row).
module tb_ql_bank_cfg_loader;

   localparam int BLW = 40;
   localparam int WLW = 3;
   localparam int DW  = 32;
   localparam int WLP = 2;
`ifdef QL_CFG_CRC_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   typedef struct {
      logic [5:0][31:0] words;
      int               gap;
      int               busyAt;
      bit               corrupt;
      int               expCycles;
      bit               busyErr;
   } vec_t;

   logic            clk = 1'b0;
   logic            globalResetn;
   logic            cfgStart;
   logic [0:BLW-1]  bl;
   logic [0:WLW-1]  wl;
   logic            fabricResetn, cfgBusy, cfgDone, cfgErr;

   int compared = 0;
   int mismatched = 0;

   vec_t           vecs [6];
   logic [0:WLW-1] rowWl [3];

   logic [0:BLW-1] pulseBl [8];
   logic [0:WLW-1] pulseWl [8];
   int             pulseLen [8];
   int             pulseCnt = 0;
   int             curLen = 0;
   int             badPulse = 0;

   ql_bank_cfg_loader_if #(.DATA_W(DW)) cfgIf ();

   ql_bank_cfg_loader #(
      .BL_WIDTH(BLW), .WL_WIDTH(WLW), .DATA_W(DW), .WL_PULSE(WLP)
   ) dut (
      .clk(clk), .global_resetn(globalResetn), .cfg_start(cfgStart), .cfg(cfgIf),
      .bl(bl), .wl(wl), .fabric_resetn(fabricResetn), .cfg_busy(cfgBusy),
      .cfg_done(cfgDone), .cfg_err(cfgErr)
   );

   always #5 clk = ~clk;

   // Records every word-line pulse: which line, how long, and bl as seen when it opened
   always @(negedge clk) begin
      #1;
      if (!globalResetn || (cfgStart && !cfgBusy)) begin
         pulseCnt = 0;
         curLen   = 0;
         badPulse = 0;
      end else if (wl != '0) begin
         if (curLen == 0 && pulseCnt < 8) begin
            pulseBl[pulseCnt] = bl;
            pulseWl[pulseCnt] = wl;
         end else if (pulseCnt < 8 && (wl !== pulseWl[pulseCnt] || bl !== pulseBl[pulseCnt])) begin
            badPulse++;
         end
         if (cfgIf.cfg_ready) badPulse++;
         curLen++;
      end else if (curLen != 0) begin
         if (pulseCnt < 8) pulseLen[pulseCnt] = curLen;
         pulseCnt++;
         curLen = 0;
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [15:0] crcModel(input logic [5:0][31:0] w);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 0; i < 6; i++) begin
         for (int b = 31; b >= 0; b--) begin
            fb = c[15] ^ w[i][b];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
         end
      end
      return c;
   endfunction

   task automatic setVec(input int i, input logic [31:0] w0, w1, w2, w3, w4, w5,
                         input int gap, input int busyAt, input bit corrupt,
                         input int expCycles, input bit busyErr);
      vecs[i].words[0] = w0;  vecs[i].words[1] = w1;
      vecs[i].words[2] = w2;  vecs[i].words[3] = w3;
      vecs[i].words[4] = w4;  vecs[i].words[5] = w5;
      vecs[i].gap       = gap;
      vecs[i].busyAt    = busyAt;
      vecs[i].corrupt   = corrupt;
      vecs[i].expCycles = expCycles;
      vecs[i].busyErr   = busyErr;
   endtask

   // Start a load, stream six words (with an optional stall after each row's first word), then check the result
   task automatic applyStimulus(input int v);
      vec_t           t;
      int             cycles, wIdx, gapLeft;
      bit             rdy, expErr;
      logic [15:0]    trailer;
      logic [0:BLW-1] expBl;
      t       = vecs[v];
      expErr  = t.busyErr | (CRC_ON & t.corrupt);
      trailer = crcModel(t.words) ^ {15'b0, t.corrupt};

      @(negedge clk);
      cfgStart = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cfgStart = 1'b0;
      checkOutput($sformatf("v%0d_start_ready", v), cfgIf.cfg_ready, 1);
      checkOutput($sformatf("v%0d_start_done", v), cfgDone, 0);
      checkOutput($sformatf("v%0d_start_fabric", v), fabricResetn, 0);
      checkOutput($sformatf("v%0d_start_err", v), cfgErr, 0);

      cycles  = 0;
      wIdx    = 0;
      gapLeft = 0;
      while (!cfgDone && cycles < 400) begin
         cfgStart = (cycles == t.busyAt);
         if (wIdx < 6 && gapLeft == 0) begin
            cfgIf.cfg_valid = 1'b1;
            cfgIf.cfg_data  = t.words[wIdx];
         end else if (wIdx == 6 && CRC_ON) begin
            cfgIf.cfg_valid = 1'b1;
            cfgIf.cfg_data  = {16'($urandom), trailer};
         end else begin
            cfgIf.cfg_valid = 1'b0;
            cfgIf.cfg_data  = $urandom;
         end
         rdy = cfgIf.cfg_ready;
         @(posedge clk);
         cycles++;
         if (cfgIf.cfg_valid && rdy) begin
            wIdx++;
            if ((wIdx % 2) == 1) gapLeft = t.gap;
         end else if (!cfgIf.cfg_valid && gapLeft > 0) begin
            gapLeft--;
         end
         @(negedge clk);
      end
      cfgStart        = 1'b0;
      cfgIf.cfg_valid = 1'b0;
      #2;

      checkOutput($sformatf("v%0d_cycles", v), cycles, t.expCycles + (CRC_ON ? 1 : 0));
      checkOutput($sformatf("v%0d_done", v), cfgDone, 1);
      checkOutput($sformatf("v%0d_fabric", v), fabricResetn, !expErr);
      checkOutput($sformatf("v%0d_err", v), cfgErr, expErr);
      checkOutput($sformatf("v%0d_busy", v), cfgBusy, 0);
      checkOutput($sformatf("v%0d_done_wl", v), wl, 0);
      checkOutput($sformatf("v%0d_done_bl", v), bl, 0);
      checkOutput($sformatf("v%0d_pulse_count", v), pulseCnt, 3);
      checkOutput($sformatf("v%0d_pulse_stable", v), badPulse, 0);
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < BLW; k++) expBl[k] = t.words[r * 2 + k / 32][k % 32];
         checkOutput($sformatf("v%0d_row%0d_wl", v, r), pulseWl[r], rowWl[r]);
         checkOutput($sformatf("v%0d_row%0d_len", v, r), pulseLen[r], WLP);
         checkOutput($sformatf("v%0d_row%0d_bl", v, r), pulseBl[r], expBl);
      end
   endtask

   initial begin
      logic [0:31] hiSlice;
      logic [0:7]  loSlice;
      int          cycles;

      rowWl[0] = 3'b100;
      rowWl[1] = 3'b010;
      rowWl[2] = 3'b001;
      //        idx  row0 w0      row0 w1      row1 w0      row1 w1      row2 w0      row2 w1    gap busy crc cyc err
      setVec(0, 32'hA5A5A5A5, 32'h000000C3, 32'h12345678, 32'hFFFFFF5A, 32'hDEADBEEF, 32'h00000081, 0, -1, 0, 18, 0);
      setVec(1, 32'hA5A5A5A5, 32'h000000C3, 32'h12345678, 32'hFFFFFF5A, 32'hDEADBEEF, 32'h00000081, 5, -1, 0, 33, 0);
      setVec(2, 32'h0000FFFF, 32'h00000011, 32'hCAFEF00D, 32'h000000E7, 32'h80000001, 32'hABCDEF3C, 0,  7, 0, 18, 1);
      setVec(3, 32'h13579BDF, 32'h0000002A, 32'h2468ACE0, 32'h00000055, 32'h0F0F0F0F, 32'h000000F0, 2, -1, 0, 24, 0);
      setVec(4, 32'hFEDCBA98, 32'h00000001, 32'h76543210, 32'h00000080, 32'h55AA55AA, 32'h0000007E, 1, -1, 1, 21, 0);
      setVec(5, 32'h01234567, 32'h000000FF, 32'h89ABCDEF, 32'h00000000, 32'hFFFFFFFF, 32'h00000018, 0, -1, 0, 18, 0);

      globalResetn    = 1'b0;
      cfgStart        = 1'b0;
      cfgIf.cfg_valid = 1'b0;
      cfgIf.cfg_data  = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_bl", bl, 0);
      checkOutput("reset_wl", wl, 0);
      checkOutput("reset_ready", cfgIf.cfg_ready, 0);
      checkOutput("reset_fabric", fabricResetn, 0);
      checkOutput("reset_busy", cfgBusy, 0);
      checkOutput("reset_done", cfgDone, 0);
      checkOutput("reset_err", cfgErr, 0);
      globalResetn = 1'b1;

      // Valid words while idle must not be taken
      cfgIf.cfg_valid = 1'b1;
      cfgIf.cfg_data  = 32'hFFFFFFFF;
      repeat (3) @(negedge clk);
      checkOutput("idle_ready", cfgIf.cfg_ready, 0);
      checkOutput("idle_bl", bl, 0);
      checkOutput("idle_busy", cfgBusy, 0);
      cfgIf.cfg_valid = 1'b0;

      for (int v = 0; v < 6; v++) begin
         applyStimulus(v);
         if (v == 0) begin
            hiSlice = pulseBl[0][0:31];
            loSlice = pulseBl[0][32:39];
            checkOutput("v0_row0_bl_word0", hiSlice, 32'hA5A5A5A5);
            checkOutput("v0_row0_bl_word1", loSlice, 8'hC3);
         end
      end

      // Reset asserted while the second word line is strobing
      @(negedge clk);
      cfgStart = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cfgStart        = 1'b0;
      cfgIf.cfg_valid = 1'b1;
      cfgIf.cfg_data  = 32'hFFFFFFFF;
      cycles = 0;
      while (wl !== 3'b010 && cycles < 100) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
      end
      checkOutput("midrst_reach_wl010", wl, 3'b010);
      globalResetn = 1'b0;
      #1;
      checkOutput("midrst_wl", wl, 0);
      checkOutput("midrst_bl", bl, 0);
      checkOutput("midrst_fabric", fabricResetn, 0);
      checkOutput("midrst_busy", cfgBusy, 0);
      @(negedge clk);
      globalResetn = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("midrst_after_ready", cfgIf.cfg_ready, 0);
      checkOutput("midrst_after_busy", cfgBusy, 0);
      checkOutput("midrst_after_done", cfgDone, 0);
      checkOutput("midrst_after_bl", bl, 0);
      cfgIf.cfg_valid = 1'b0;

      applyStimulus(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
